commit_queue: RTL and testbench

- In-order retire buffer that drives the scoreboard side of the commit interface.
- Issue allocates entries, functional-unit writeback marks them complete, and the oldest NR_COMMIT_PORTS entries are presented to the commit stage.
- Entries are popped on the commit stage's per-port acknowledge.
- Replaces the commit-facing half of the scoreboard with a standalone, separately verifiable block.

---
 rtl/commit_queue.sv | 204 ++++++++++++++++++++
 tb/tb_commit_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_queue.sv
// commit_queue: in-order retire buffer feeding the commit stage from issue/writeback.
// Latency: writeback -> commit .valid is 1 cycle (0 cycles with COMMIT_QUEUE_WB_FWD_EN).
// Backpressure: alloc_ready_o drops when full (registered count) or during flush.
//
// Optional macro COMMIT_QUEUE_WB_FWD_EN: forwards same-cycle writeback onto commit ports.
// Ports:
//   clk_i, rst_ni (async, active-low), flush_i       clock / reset / drop all entries
//   alloc_valid_i, alloc_entry_i, alloc_ready_o,
//   alloc_trans_id_o                                  issue-side allocation (id = tail)
//   wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_i   functional-unit writeback
//   commit_instr_o, commit_ack_i                      oldest entries and per-port retire
//   empty_o                                           no occupied entries

package commit_queue_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [7:0]      trans_id;
        logic [3:0]      fu;
        logic [7:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic            valid;
        exception_t      ex;
    } scoreboard_entry_t;
endpackage

module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_WB_PORTS     = 4,
    localparam int IDX_W          = $clog2(NR_ENTRIES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  alloc_valid_i,
    input  scoreboard_entry_t                     alloc_entry_i,
    output logic                                  alloc_ready_o,
    output logic [IDX_W-1:0]                      alloc_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDX_W-1:0]     wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]      wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]          wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
    output logic                                  empty_o
);

    logic [IDX_W-1:0]        r_head;
    logic [IDX_W-1:0]        r_tail;
    logic [IDX_W:0]          r_count;
    logic [NR_ENTRIES-1:0]   r_occ;
    logic [NR_ENTRIES-1:0]   r_done;
    scoreboard_entry_t       r_mem [NR_ENTRIES];

    logic                    w_alloc;
    logic [NR_ENTRIES-1:0]   w_wb_hit;
    logic [NR_ENTRIES-1:0]   w_wb_upd;
    logic [XLEN-1:0]         w_wb_res [NR_ENTRIES];
    exception_t              w_wb_ex  [NR_ENTRIES];
    logic [IDX_W-1:0]        w_cidx   [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] w_cvalid;
    logic [NR_COMMIT_PORTS-1:0] w_pop;
    logic                    w_chain;
    logic [IDX_W:0]          w_pop_cnt;
    logic [NR_ENTRIES-1:0]   w_clr;

    // Space is judged on registered count only; a same-cycle pop does not free a slot.
    assign alloc_ready_o    = (r_count != (IDX_W+1)'(NR_ENTRIES)) && !flush_i;
    assign alloc_trans_id_o = r_tail;
    assign empty_o          = (r_count == '0);
    assign w_alloc          = alloc_valid_i && alloc_ready_o;

    // Per-entry writeback select; iterating from the highest port down lets the lowest port win.
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            w_wb_hit[e] = 1'b0;
            w_wb_res[e] = '0;
            w_wb_ex[e]  = '0;
            for (int p = NR_WB_PORTS-1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_trans_id_i[p] == IDX_W'(e))) begin
                    w_wb_hit[e] = 1'b1;
                    w_wb_res[e] = wb_result_i[p];
                    w_wb_ex[e]  = wb_ex_i[p];
                end
            end
        end
        // A done entry (including one that faulted at decode) is never rewritten.
        w_wb_upd = w_wb_hit & r_occ & ~r_done;
    end

    // Commit presentation of the oldest entries; pointer arithmetic wraps naturally.
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_cidx[i]         = r_head + IDX_W'(i);
            commit_instr_o[i] = r_mem[w_cidx[i]];
            w_cvalid[i]       = r_occ[w_cidx[i]] && r_done[w_cidx[i]] &&
                                ((IDX_W+1)'(i) < r_count);
`ifdef COMMIT_QUEUE_WB_FWD_EN
            if (w_wb_upd[w_cidx[i]] && ((IDX_W+1)'(i) < r_count)) begin
                commit_instr_o[i].result = w_wb_res[w_cidx[i]];
                commit_instr_o[i].ex     = w_wb_ex[w_cidx[i]];
                w_cvalid[i]              = 1'b1;
            end
`endif
            commit_instr_o[i].valid = w_cvalid[i];
        end
    end

    // Pops form a contiguous prefix: an ack on a non-valid port stops all higher ports.
    always_comb begin
        w_chain   = 1'b1;
        w_pop_cnt = '0;
        w_clr     = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_chain   = w_chain && commit_ack_i[i] && w_cvalid[i];
            w_pop[i]  = w_chain;
            w_pop_cnt = w_pop_cnt + (IDX_W+1)'(w_chain);
            if (w_chain) begin
                w_clr[w_cidx[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_occ   <= '0;
            r_done  <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_occ   <= '0;
            r_done  <= '0;
        end else begin
            r_head  <= r_head + w_pop_cnt[IDX_W-1:0];
            r_count <= r_count + (IDX_W+1)'(w_alloc) - w_pop_cnt;
            if (w_alloc) begin
                r_tail <= r_tail + IDX_W'(1);
            end
            // The tail slot is never occupied when allocating, so it cannot also be popped.
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (w_alloc && (r_tail == IDX_W'(e))) begin
                    r_occ[e]  <= 1'b1;
                    r_done[e] <= alloc_entry_i.ex.valid;
                end else if (w_clr[e]) begin
                    r_occ[e]  <= 1'b0;
                    r_done[e] <= 1'b0;
                end else if (w_wb_upd[e]) begin
                    r_done[e] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through occupied/done.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            if (!flush_i) begin
                if (w_alloc && (r_tail == IDX_W'(e))) begin
                    r_mem[e]          <= alloc_entry_i;
                    r_mem[e].result   <= '0;
                    r_mem[e].valid    <= 1'b0;
                    r_mem[e].trans_id <= 8'(e);
                end else if (w_wb_upd[e]) begin
                    r_mem[e].result <= w_wb_res[e];
                    r_mem[e].ex     <= w_wb_ex[e];
                end
            end
        end
    end

    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_count <= (IDX_W+1)'(NR_ENTRIES));

    // Protocol checks on the neighbours are warnings: the block tolerates these cases.
    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_chk
        a_wb_not_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (wb_valid_i[p] && !flush_i) |-> !(r_occ[wb_trans_id_i[p]] && r_done[wb_trans_id_i[p]]))
            else $warning("commit_queue: writeback to an already completed entry");
    end

    if (NR_COMMIT_PORTS > 1) begin : g_ack_chk
        a_ack_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
            commit_ack_i[1] |-> commit_ack_i[0])
            else $warning("commit_queue: ack on port 1 without port 0");
    end

endmodule

// File: tb/tb_commit_queue.sv
// tb_commit_queue: directed stimulus for commit_queue with a queue-based reference model.
// Latency: model and DUT compared every cycle shortly after the falling edge.
// Backpressure: bench honours alloc_ready_o as the model predicts it.
module tb_commit_queue;
    import commit_queue_pkg::*;

    localparam int N  = 8;
    localparam int NC = 2;
    localparam int NW = 4;
    localparam int IW = 3;

    logic                          clk_i = 1'b0;
    logic                          rst_ni = 1'b0;
    logic                          flush_i;
    logic                          alloc_valid_i;
    scoreboard_entry_t             alloc_entry_i;
    logic                          alloc_ready_o;
    logic [IW-1:0]                 alloc_trans_id_o;
    logic [NW-1:0]                 wb_valid_i;
    logic [NW-1:0][IW-1:0]         wb_trans_id_i;
    logic [NW-1:0][XLEN-1:0]       wb_result_i;
    exception_t [NW-1:0]           wb_ex_i;
    scoreboard_entry_t [NC-1:0]    commit_instr_o;
    logic [NC-1:0]                 commit_ack_i;
    logic                          empty_o;

    always #5 clk_i = ~clk_i;

    commit_queue #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_entry_i(alloc_entry_i),
        .alloc_ready_o(alloc_ready_o), .alloc_trans_id_o(alloc_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
        .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
        .commit_instr_o(commit_instr_o), .commit_ack_i(commit_ack_i),
        .empty_o(empty_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of live instructions, oldest first.
    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        done;
        logic [31:0] res;
        logic        exv;
    } mrec_t;

    mrec_t mq[$];
    int    m_tail   = 0;
    int    m_popped = 0;

    function automatic void exp_port(input int i, output logic v, output logic [31:0] res,
                                     output logic exv);
        v = 1'b0; res = '0; exv = 1'b0;
        if (i < mq.size()) begin
            v   = mq[i].done;
            res = mq[i].res;
            exv = mq[i].exv;
`ifdef COMMIT_QUEUE_WB_FWD_EN
            if (!mq[i].done) begin
                for (int p = NW-1; p >= 0; p--) begin
                    if (wb_valid_i[p] && (int'(wb_trans_id_i[p]) == mq[i].id)) begin
                        v   = 1'b1;
                        res = wb_result_i[p];
                        exv = wb_ex_i[p].valid;
                    end
                end
            end
`endif
        end
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk_i) begin : compare
        logic        v;
        logic [31:0] r;
        logic        x;
        if (rst_ni) begin
            #2;
            chk("alloc_ready", alloc_ready_o, (mq.size() != N) && !flush_i);
            chk("alloc_trans_id", alloc_trans_id_o, m_tail);
            chk("empty", empty_o, mq.size() == 0);
            for (int i = 0; i < NC; i++) begin
                exp_port(i, v, r, x);
                chk($sformatf("c%0d_valid", i), commit_instr_o[i].valid, v);
                if (v) begin
                    chk($sformatf("c%0d_result", i), commit_instr_o[i].result, r);
                    chk($sformatf("c%0d_exv", i), commit_instr_o[i].ex.valid, x);
                    chk($sformatf("c%0d_pc", i), commit_instr_o[i].pc, mq[i].pc);
                    chk($sformatf("c%0d_id", i), commit_instr_o[i].trans_id, mq[i].id);
                end
            end
        end
    end

    // Model update on the active edge from the inputs held over the cycle.
    always @(posedge clk_i) begin : model
        logic        rdy, v0, v1, x;
        logic [31:0] r;
        int          n;
        mrec_t       rec;
        if (rst_ni) begin
            rdy = (mq.size() != N) && !flush_i;
            n   = 0;
            if (flush_i) begin
                mq.delete();
                m_tail = 0;
            end else begin
                exp_port(0, v0, r, x);
                exp_port(1, v1, r, x);
                if (commit_ack_i[0] && v0) n = (commit_ack_i[1] && v1) ? 2 : 1;
                for (int p = 0; p < NW; p++) begin
                    if (wb_valid_i[p]) begin
                        foreach (mq[k]) begin
                            if (mq[k].id == int'(wb_trans_id_i[p]) && !mq[k].done) begin
                                mq[k].done = 1'b1;
                                mq[k].res  = wb_result_i[p];
                                mq[k].exv  = wb_ex_i[p].valid;
                            end
                        end
                    end
                end
                repeat (n) begin
                    void'(mq.pop_front());
                    m_popped++;
                end
                if (alloc_valid_i && rdy) begin
                    rec.id   = m_tail;
                    rec.pc   = alloc_entry_i.pc;
                    rec.done = alloc_entry_i.ex.valid;
                    rec.res  = '0;
                    rec.exv  = alloc_entry_i.ex.valid;
                    mq.push_back(rec);
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
    end

    task automatic idle();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        alloc_entry_i = '0;
        wb_valid_i    = '0;
        wb_trans_id_i = '0;
        wb_result_i   = '0;
        wb_ex_i       = '0;
        commit_ack_i  = '0;
    endtask

    task automatic nxt();
        @(negedge clk_i);
        idle();
        #1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic exv);
        alloc_valid_i          = 1'b1;
        alloc_entry_i          = '0;
        alloc_entry_i.pc       = pc;
        alloc_entry_i.op       = pc[7:0];
        alloc_entry_i.ex.valid = exv;
    endtask

    task automatic wb(input int p, input int id, input logic [31:0] r);
        wb_valid_i[p]    = 1'b1;
        wb_trans_id_i[p] = IW'(id);
        wb_result_i[p]   = r;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (!empty_o && k < 30) begin
            commit_ack_i = 2'b11;
            nxt();
            k++;
        end
        chk(nm, empty_o, 1'b1);
    endtask

    initial begin : stim
        int p0;
        idle();
        #3;
        chk("in_reset_empty", empty_o, 1'b1);
        #19 rst_ni = 1'b1;
        @(negedge clk_i);
        #1;

        // Reset state
        chk("rst_ready", alloc_ready_o, 1'b1);
        chk("rst_id", alloc_trans_id_o, 0);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_v0", commit_instr_o[0].valid, 1'b0);
        chk("rst_v1", commit_instr_o[1].valid, 1'b0);

        // Basic alloc / out-of-order writeback / in-order commit
        for (int i = 0; i < 3; i++) begin
            alloc(32'h100 + 32'(4*i), 1'b0);
            nxt();
        end
        wb(0, 2, 32'h33); nxt();
        wb(0, 0, 32'h11); nxt();
        chk("t2_v0", commit_instr_o[0].valid, 1'b1);
        chk("t2_r0", commit_instr_o[0].result, 32'h11);
        chk("t2_v1", commit_instr_o[1].valid, 1'b0);
        commit_ack_i = 2'b01; nxt();
        wb(1, 1, 32'h22); nxt();
        chk("t2b_v0", commit_instr_o[0].valid, 1'b1);
        chk("t2b_r0", commit_instr_o[0].result, 32'h22);
        chk("t2b_v1", commit_instr_o[1].valid, 1'b1);
        chk("t2b_r1", commit_instr_o[1].result, 32'h33);
        chk("t2b_id1", commit_instr_o[1].trans_id, 2);
        commit_ack_i = 2'b11; nxt();
        chk("t2_empty", empty_o, 1'b1);

        // Full queue; pop in the same cycle does not free space
        for (int i = 0; i < 8; i++) begin
            alloc(32'h200 + 32'(4*i), 1'b0);
            nxt();
        end
        chk("t3_full_ready", alloc_ready_o, 1'b0);
        wb(0, 3, 32'h300); wb(1, 4, 32'h304); nxt();
        alloc(32'h2ff, 1'b0);
        commit_ack_i = 2'b11;
        #1 chk("t3_refused", alloc_ready_o, 1'b0);
        nxt();
        chk("t3_ready_after", alloc_ready_o, 1'b1);
        chk("t3_count", dut.r_count, 6);
        chk("t3_tail", alloc_trans_id_o, 3);
        for (int i = 0; i < 6; i++) begin
            wb(0, (5 + i) % 8, 32'h305 + 32'(i));
            nxt();
        end
        drain("t3_drained");

        // Wrap-around streaming
        p0 = m_popped;
        for (int i = 0; i < 20; i++) begin
            alloc(32'h400 + 32'(i), 1'b0);
            if (i > 0) wb(0, (3 + i - 1) % 8, 32'h4000 + 32'(i));
            commit_ack_i = 2'b01;
            nxt();
        end
        wb(0, (3 + 19) % 8, 32'h4fff); nxt();
        drain("t4_drained");
        chk("t4_pops", m_popped - p0, 20);
        chk("t4_tail", alloc_trans_id_o, 7);

        // Flush with concurrent alloc and ack
        for (int i = 0; i < 4; i++) begin
            alloc(32'h500 + 32'(4*i), 1'b0);
            nxt();
        end
        wb(0, 7, 32'h57); wb(1, 0, 32'h50); nxt();
        flush_i = 1'b1;
        alloc(32'h5ff, 1'b0);
        commit_ack_i = 2'b01;
        #1;
        chk("t5_flush_ready", alloc_ready_o, 1'b0);
        chk("t5_preflush_v0", commit_instr_o[0].valid, 1'b1);
        nxt();
        chk("t5_empty", empty_o, 1'b1);
        chk("t5_count", dut.r_count, 0);
        chk("t5_tail", alloc_trans_id_o, 0);
        chk("t5_v0", commit_instr_o[0].valid, 1'b0);
        chk("t5_v1", commit_instr_o[1].valid, 1'b0);
        wb(0, 1, 32'h55); nxt();
        chk("t5_wb_ignored_v0", commit_instr_o[0].valid, 1'b0);
        chk("t5_wb_ignored_empty", empty_o, 1'b1);

        // Decode exception, stray ack[1], duplicate writeback, forwarding
        alloc(32'h600, 1'b1); nxt();
        chk("t6_ex_v0", commit_instr_o[0].valid, 1'b1);
        chk("t6_ex_flag", commit_instr_o[0].ex.valid, 1'b1);
        chk("t6_ex_res", commit_instr_o[0].result, 0);
        commit_ack_i = 2'b10; nxt();
        chk("t6_ack1_only", empty_o, 1'b0);
        commit_ack_i = 2'b01; nxt();
        chk("t6_ack0", empty_o, 1'b1);
        alloc(32'h604, 1'b0); nxt();
        wb(0, 1, 32'hA); wb(2, 1, 32'hB); nxt();
        chk("t6_dup_v0", commit_instr_o[0].valid, 1'b1);
        chk("t6_dup_res", commit_instr_o[0].result, 32'hA);
        commit_ack_i = 2'b01; nxt();
        alloc(32'h608, 1'b0); nxt();
        wb(1, 2, 32'hC);
        #1;
`ifdef COMMIT_QUEUE_WB_FWD_EN
        chk("t6_fwd_v0", commit_instr_o[0].valid, 1'b1);
        chk("t6_fwd_res", commit_instr_o[0].result, 32'hC);
`else
        chk("t6_nofwd_v0", commit_instr_o[0].valid, 1'b0);
`endif
        nxt();
        chk("t6_wb_v0", commit_instr_o[0].valid, 1'b1);
        chk("t6_wb_res", commit_instr_o[0].result, 32'hC);
        commit_ack_i = 2'b01; nxt();
        chk("t6_final_empty", empty_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
